pc_gen_unit: RTL and testbench

- Next-generation fetch-address generator: owns the PC register instead of only computing pc_next.
- Selects among sequential, conditional branch, direct jump, register jump, exception vector and exception return.
- Supports pipeline stall, halt/resume, misaligned-target fault capture, and an EPC register.
- Sits at the front of the pipeline; drives the instruction memory address and the IF/ID pc field.

---
 rtl/pc_gen_unit_pkg.sv | 32 +++
 rtl/pc_gen_unit_if.sv | 41 ++++
 rtl/pc_gen_unit_pc_target_calc.sv | 52 +++++
 rtl/pc_gen_unit.sv | 138 +++++++++++++
 tb/tb_pc_gen_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the fetch-address generator: FSM state encoding,
// next-PC select codes and default vector constants.
package pc_gen_unit_pkg;

   localparam int unsigned ADDR_BITS_DEF   = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;
   localparam int unsigned BR_BASE_ADJ_DEF = 4;

   // FSM state encoding (2 bits)
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_HALTED   = 2'd1;
   localparam logic [1:0] ST_EXC_WAIT = 2'd2;

   // Next-PC source select
   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_HOLD = 3'd1,
      SEL_BR   = 3'd2,
      SEL_J    = 3'd3,
      SEL_JR   = 3'd4,
      SEL_EXC  = 3'd5,
      SEL_ERET = 3'd6
   } pc_sel_e;

   // True for selects whose target comes from the target calculator and
   // therefore must be word aligned.
   function automatic logic is_calc_target(input pc_sel_e sel);
      return (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR) || (sel == SEL_ERET);
   endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Control/redirect bus between the pipeline and the PC generator.
//   master: pipeline side, drives redirect requests, observes PC state.
//   slave : pc_gen_unit side.
interface pc_gen_unit_if
   import pc_gen_unit_pkg::*;
#(
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
);
   logic                 stall;
   logic                 halt_req;
   logic                 resume;
   logic                 br_taken;
   logic [ADDR_BITS-1:0] br_pc;
   logic [15:0]          imm_16;
   logic                 jmp;
   logic                 jr;
   logic [25:0]          imm_26;
   logic [31:0]          jr_target;
   logic                 exc_req;
   logic [ADDR_BITS-1:0] exc_pc;
   logic                 eret;

   logic [ADDR_BITS-1:0] pc;
   logic [ADDR_BITS-1:0] pc_plus4;
   logic [ADDR_BITS-1:0] epc;
   logic                 misalign;
   logic                 halted;
   logic                 redirect;

   modport master (
      output stall, halt_req, resume, br_taken, br_pc, imm_16, jmp, jr,
             imm_26, jr_target, exc_req, exc_pc, eret,
      input  pc, pc_plus4, epc, misalign, halted, redirect
   );

   modport slave (
      input  stall, halt_req, resume, br_taken, br_pc, imm_16, jmp, jr,
             imm_26, jr_target, exc_req, exc_pc, eret,
      output pc, pc_plus4, epc, misalign, halted, redirect
   );
endinterface

// File: rtl/pc_gen_unit_pc_target_calc.sv
// Combinational redirect-target calculator.
//   sel          : next-PC source chosen by the controller
//   pc, br_pc,
//   epc          : current PC, resolving-branch PC, saved exception PC
//   imm_16/26    : branch word offset / direct jump field
//   jr_target    : register operand for jr
//   target_c     : selected redirect target (branch, jump, jr or eret)
//   misaligned_c : selected target is not word aligned
module pc_target_calc
   import pc_gen_unit_pkg::*;
#(
   parameter int unsigned ADDR_BITS   = ADDR_BITS_DEF,
   parameter int unsigned BR_BASE_ADJ = BR_BASE_ADJ_DEF
) (
   input  pc_sel_e              sel,
   input  logic [ADDR_BITS-1:0] pc,
   input  logic [ADDR_BITS-1:0] br_pc,
   input  logic [ADDR_BITS-1:0] epc,
   input  logic [15:0]          imm_16,
   input  logic [25:0]          imm_26,
   input  logic [31:0]          jr_target,
   output logic [ADDR_BITS-1:0] target_c,
   output logic                 misaligned_c
);

   // Keeps the upper address region of pc; the jump field fills bits [27:0].
   localparam logic [ADDR_BITS-1:0] REGION_MASK = ~ADDR_BITS'(28'hFFF_FFFF);

   logic [ADDR_BITS-1:0] br_off;
   logic [ADDR_BITS-1:0] br_target;
   logic [ADDR_BITS-1:0] j_target;
   logic [ADDR_BITS-1:0] jr_tgt;

   assign br_off    = {{(ADDR_BITS-18){imm_16[15]}}, imm_16, 2'b00};
   assign br_target = br_pc - ADDR_BITS'(BR_BASE_ADJ) + br_off;
   assign j_target  = (pc & REGION_MASK) | ADDR_BITS'({imm_26, 2'b00});
   assign jr_tgt    = ADDR_BITS'(jr_target);

   // Target mux and alignment check
   always_comb begin
      target_c = pc;
      case (sel)
         SEL_BR:   target_c = br_target;
         SEL_J:    target_c = j_target;
         SEL_JR:   target_c = jr_tgt;
         SEL_ERET: target_c = epc;
         default:  target_c = pc;
      endcase
      misaligned_c = is_calc_target(sel) && (target_c[1:0] != 2'b00);
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-address generator: owns the PC and EPC registers and a small
// RUN/HALTED/EXC_WAIT controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : redirect requests in (stall, halt/resume, branch, jump, jr,
//              exception, eret); pc, pc_plus4, epc, misalign, halted,
//              redirect out. pc_plus4 is combinational from pc.
module pc_gen_unit
   import pc_gen_unit_pkg::*;
#(
   parameter int unsigned          ADDR_BITS    = ADDR_BITS_DEF,
   parameter logic [ADDR_BITS-1:0] RESET_VECTOR = ADDR_BITS'(RESET_VECTOR_DEF),
   parameter logic [ADDR_BITS-1:0] EXC_VECTOR   = ADDR_BITS'(EXC_VECTOR_DEF),
   parameter int unsigned          BR_BASE_ADJ  = BR_BASE_ADJ_DEF
) (
   input logic          clk,
   input logic          rst,
   pc_gen_unit_if.slave bus
);

   logic [1:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] pc_q, pc_d;
   logic [ADDR_BITS-1:0] epc_q, epc_d;
   logic                 misalign_q, misalign_d;
   logic                 halted_q;
   logic                 redirect_q, redirect_d;
   pc_sel_e              sel;
   logic [ADDR_BITS-1:0] target_c;
   logic                 misaligned_c;
   logic                 fault;

   pc_target_calc #(
      .ADDR_BITS   (ADDR_BITS),
      .BR_BASE_ADJ (BR_BASE_ADJ)
   ) u_target_calc (
      .sel          (sel),
      .pc           (pc_q),
      .br_pc        (bus.br_pc),
      .epc          (epc_q),
      .imm_16       (bus.imm_16),
      .imm_26       (bus.imm_26),
      .jr_target    (bus.jr_target),
      .target_c     (target_c),
      .misaligned_c (misaligned_c)
   );

   // State and PC-related registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         misalign_q <= 1'b0;
         halted_q   <= 1'b0;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         misalign_q <= misalign_d;
         halted_q   <= (state_d == ST_HALTED);
         redirect_q <= redirect_d;
      end
   end

   // Next-PC select, next state and register updates
   always_comb begin
      sel        = SEL_HOLD;
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      misalign_d = misalign_q;
      redirect_d = 1'b0;
      fault      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bus.exc_req)       sel = SEL_EXC;
            else if (bus.eret)     sel = SEL_ERET;
            else if (bus.br_taken) sel = SEL_BR;
            else if (bus.jmp)      sel = bus.jr ? SEL_JR : SEL_J;
            else if (bus.stall)    sel = SEL_HOLD;
            else                   sel = SEL_SEQ;
         end
         ST_HALTED: begin
            if (bus.exc_req)     sel = SEL_EXC;
            else if (bus.resume) sel = bus.stall ? SEL_HOLD : SEL_SEQ;
            else                 sel = SEL_HOLD;
         end
         // One bubble cycle after a vector load: only sequential fetch.
         ST_EXC_WAIT: sel = bus.stall ? SEL_HOLD : SEL_SEQ;
         default:     sel = SEL_HOLD;
      endcase

      // A misaligned redirect target is converted into a vector load.
      fault = misaligned_c;

      case (sel)
         SEL_SEQ:  pc_d = pc_q + ADDR_BITS'(4);
         SEL_HOLD: pc_d = pc_q;
         SEL_EXC: begin
            pc_d  = EXC_VECTOR;
            epc_d = bus.exc_pc;
         end
         default: begin
            if (fault) begin
               pc_d       = EXC_VECTOR;
               epc_d      = target_c;
               misalign_d = 1'b1;
            end else begin
               pc_d = target_c;
            end
         end
      endcase

      redirect_d = (sel != SEL_SEQ) && (sel != SEL_HOLD);

      case (state_q)
         ST_RUN: begin
            if ((sel == SEL_EXC) || fault) state_d = ST_EXC_WAIT;
            else if (bus.halt_req)         state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (sel == SEL_EXC)  state_d = ST_EXC_WAIT;
            else if (bus.resume) state_d = ST_RUN;
         end
         ST_EXC_WAIT: state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_q + ADDR_BITS'(4);
   assign bus.epc      = epc_q;
   assign bus.misalign = misalign_q;
   assign bus.halted   = halted_q;
   assign bus.redirect = redirect_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with hand-computed expected values.
module tb_pc_gen_unit;
   import pc_gen_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   pc_gen_unit_if #(.ADDR_BITS(32)) bus ();

   pc_gen_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one edge, sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.stall     = 1'b0;
      bus.halt_req  = 1'b0;
      bus.resume    = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_pc     = 32'h0;
      bus.imm_16    = 16'h0;
      bus.jmp       = 1'b0;
      bus.jr        = 1'b0;
      bus.imm_26    = 26'h0;
      bus.jr_target = 32'h0;
      bus.exc_req   = 1'b0;
      bus.exc_pc    = 32'h0;
      bus.eret      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      check("rst_pc", bus.pc, 32'h3000);
      check("rst_plus4", bus.pc_plus4, 32'h3004);
      check("rst_halted", 32'(bus.halted), 32'h0);
      check("rst_epc", bus.epc, 32'h0);
      check("rst_misalign", 32'(bus.misalign), 32'h0);
      check("rst_redirect", 32'(bus.redirect), 32'h0);

      // Free-running sequential fetch
      rst = 1'b0;
      step(); check("seq1", bus.pc, 32'h3004);
      step(); check("seq2", bus.pc, 32'h3008);
      step(); check("seq3", bus.pc, 32'h300C);
      check("seq_redirect", 32'(bus.redirect), 32'h0);
      step(); check("seq4", bus.pc, 32'h3010);

      // Backward branch: 0x3010 - 4 + (-2 << 2) = 0x3004
      bus.br_taken = 1'b1; bus.br_pc = 32'h3010; bus.imm_16 = 16'hFFFE;
      step(); check("br_pc", bus.pc, 32'h3004);
      check("br_redirect", 32'(bus.redirect), 32'h1);
      bus.br_taken = 1'b0;
      step(); check("br_after", bus.pc, 32'h3008);
      check("br_after_redirect", 32'(bus.redirect), 32'h0);

      // Branch overrides stall
      bus.br_taken = 1'b1; bus.stall = 1'b1;
      step(); check("br_stall_pc", bus.pc, 32'h3004);
      check("br_stall_redirect", 32'(bus.redirect), 32'h1);
      bus.br_taken = 1'b0;
      step(); check("stall_hold", bus.pc, 32'h3004);
      check("stall_redirect", 32'(bus.redirect), 32'h0);
      bus.stall = 1'b0;

      // Branch wins over a simultaneous jump
      bus.br_taken = 1'b1; bus.br_pc = 32'h3040; bus.imm_16 = 16'h0002;
      bus.jmp = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h5000;
      step(); check("br_over_jmp", bus.pc, 32'h3044);
      clear_inputs();

      // Jumps
      bus.jmp = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h3000;
      step(); check("jr_to_3000", bus.pc, 32'h3000);
      bus.jr = 1'b0; bus.imm_26 = 26'h0000C40;
      step(); check("j_pc", bus.pc, 32'h3100);
      check("j_redirect", 32'(bus.redirect), 32'h1);
      bus.jr = 1'b1; bus.jr_target = 32'h3200;
      step(); check("jr_pc", bus.pc, 32'h3200);
      check("jr_misalign_clear", 32'(bus.misalign), 32'h0);
      bus.jr_target = 32'h3202;
      step(); check("mis_pc", bus.pc, 32'h4180);
      check("mis_epc", bus.epc, 32'h3202);
      check("mis_flag", 32'(bus.misalign), 32'h1);
      check("mis_redirect", 32'(bus.redirect), 32'h1);
      clear_inputs();
      step(); check("exc_wait_seq", bus.pc, 32'h4184);
      check("exc_wait_redirect", 32'(bus.redirect), 32'h0);

      // Exception beats branch; eret ignored in EXC_WAIT
      bus.exc_req = 1'b1; bus.exc_pc = 32'h3008;
      bus.br_taken = 1'b1; bus.br_pc = 32'h3010; bus.imm_16 = 16'hFFFE;
      step(); check("exc_pc", bus.pc, 32'h4180);
      check("exc_epc", bus.epc, 32'h3008);
      check("exc_redirect", 32'(bus.redirect), 32'h1);
      clear_inputs();
      bus.eret = 1'b1;
      step(); check("eret_ignored", bus.pc, 32'h4184);
      check("eret_ignored_redirect", 32'(bus.redirect), 32'h0);
      step(); check("eret_pc", bus.pc, 32'h3008);
      check("eret_redirect", 32'(bus.redirect), 32'h1);
      check("sticky_misalign", 32'(bus.misalign), 32'h1);
      bus.eret = 1'b0;

      // Advance to 0x3020 and halt
      for (int i = 0; i < 6; i++) step();
      check("pre_halt_pc", bus.pc, 32'h3020);
      bus.halt_req = 1'b1;
      step(); check("halt_pc", bus.pc, 32'h3024);
      check("halt_flag", 32'(bus.halted), 32'h1);
      bus.halt_req = 1'b0;
      // Jumps are not honoured while halted
      bus.jmp = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h3200;
      for (int i = 0; i < 10; i++) begin
         step();
         check("halted_pc", bus.pc, 32'h3024);
         check("halted_flag", 32'(bus.halted), 32'h1);
      end
      clear_inputs();
      bus.resume = 1'b1;
      step(); check("resume_pc", bus.pc, 32'h3028);
      check("resume_flag", 32'(bus.halted), 32'h0);
      bus.resume = 1'b0;

      // Wrap-around of sequential fetch
      bus.jmp = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
      step(); check("top_pc", bus.pc, 32'hFFFF_FFFC);
      check("top_plus4", bus.pc_plus4, 32'h0000_0000);
      clear_inputs();
      step(); check("wrap_pc", bus.pc, 32'h0000_0000);

      // Reset while halted with misalign set
      bus.halt_req = 1'b1;
      step(); check("halt2_pc", bus.pc, 32'h0000_0004);
      check("halt2_flag", 32'(bus.halted), 32'h1);
      bus.halt_req = 1'b0;
      rst = 1'b1;
      step();
      check("rst2_pc", bus.pc, 32'h3000);
      check("rst2_epc", bus.epc, 32'h0);
      check("rst2_misalign", 32'(bus.misalign), 32'h0);
      check("rst2_halted", 32'(bus.halted), 32'h0);
      check("rst2_redirect", 32'(bus.redirect), 32'h0);
      rst = 1'b0;
      step(); check("post_rst_seq", bus.pc, 32'h3004);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
